// File: rtl/forward_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit_if
//   Bundle of pipeline-side signals exchanged with the forwarding/hazard unit.
//   master : pipeline side. It drives the register addresses and control bits
//            and receives the bypass selects and stall/flush controls.
//   slave  : forwarding/hazard unit side.
//   Ports (slave view):
//     in  Rs_ID, Rt_ID, UsesRt_ID                   ID-stage sources
//     in  Rs_EX, Rt_EX                              EX-stage sources
//     in  RegWrite_EX, MemRead_EX, WriteRegAddress_EX
//     in  RegWrite_MEM, MemRead_MEM, WriteRegAddress_MEM
//     in  MemReq_MEM, MemReady_MEM                  data-memory handshake
//     in  RegWrite_WB, WriteRegAddress_WB
//     out ReadData1Sel_ID, ReadData2Sel_ID          0=regfile, 1=WB data
//     out ReadData1Sel_EX, ReadData2Sel_EX          0=ID/EX, 1=MEM, 2=WB
//     out Stall_Front, Stall_Back, Flush_EX, Bubble_WB
//     out StallCycles, MemTimeout
// ---------------------------------------------------------------------------
interface forward_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] Rs_ID;
    logic [ADDR_W-1:0] Rt_ID;
    logic              UsesRt_ID;
    logic [ADDR_W-1:0] Rs_EX;
    logic [ADDR_W-1:0] Rt_EX;
    logic              RegWrite_EX;
    logic              MemRead_EX;
    logic [ADDR_W-1:0] WriteRegAddress_EX;
    logic              RegWrite_MEM;
    logic              MemRead_MEM;
    logic [ADDR_W-1:0] WriteRegAddress_MEM;
    logic              MemReq_MEM;
    logic              MemReady_MEM;
    logic              RegWrite_WB;
    logic [ADDR_W-1:0] WriteRegAddress_WB;

    logic              ReadData1Sel_ID;
    logic              ReadData2Sel_ID;
    logic [1:0]        ReadData1Sel_EX;
    logic [1:0]        ReadData2Sel_EX;
    logic              Stall_Front;
    logic              Stall_Back;
    logic              Flush_EX;
    logic              Bubble_WB;
    logic [CNT_W-1:0]  StallCycles;
    logic              MemTimeout;

    modport master (
        output Rs_ID, Rt_ID, UsesRt_ID, Rs_EX, Rt_EX,
               RegWrite_EX, MemRead_EX, WriteRegAddress_EX,
               RegWrite_MEM, MemRead_MEM, WriteRegAddress_MEM,
               MemReq_MEM, MemReady_MEM, RegWrite_WB, WriteRegAddress_WB,
        input  ReadData1Sel_ID, ReadData2Sel_ID, ReadData1Sel_EX, ReadData2Sel_EX,
               Stall_Front, Stall_Back, Flush_EX, Bubble_WB, StallCycles, MemTimeout
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRt_ID, Rs_EX, Rt_EX,
               RegWrite_EX, MemRead_EX, WriteRegAddress_EX,
               RegWrite_MEM, MemRead_MEM, WriteRegAddress_MEM,
               MemReq_MEM, MemReady_MEM, RegWrite_WB, WriteRegAddress_WB,
        output ReadData1Sel_ID, ReadData2Sel_ID, ReadData1Sel_EX, ReadData2Sel_EX,
               Stall_Front, Stall_Back, Flush_EX, Bubble_WB, StallCycles, MemTimeout
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit
//   Forwarding and hazard control for a 5-stage MIPS pipeline.
//   - ID/EX operand bypass selects, with optional register-0 suppression.
//   - Load-use detection that inserts LOAD_USE_BUBBLES bubbles (1..3).
//   - Whole-pipeline freeze while data memory is not ready.
//   - Saturating stall-cycle counter and sticky memory-timeout flag.
//   Ports:
//     Clk    in  clock, rising edge
//     Reset  in  synchronous, active-high reset
//     hz     forward_hazard_unit_if.slave (ADDR_W/CNT_W must match this module)
// ---------------------------------------------------------------------------
module forward_hazard_unit #(
    parameter int ADDR_W           = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int ZERO_REG_EN      = 1,
    parameter int MEM_TIMEOUT      = 64,
    parameter int CNT_W            = 16
) (
    input logic                  Clk,
    input logic                  Reset,
    forward_hazard_unit_if.slave hz
);
    localparam int              TO_W         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]      BUBBLES_LEFT = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [TO_W-1:0] TO_LAST      = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT       = TO_W'(MEM_TIMEOUT);

    typedef enum logic {RUN, BUBBLE} hazState_t;

    hazState_t         state;
    logic [1:0]        remaining;      // bubbles still owed after the current one
    logic [CNT_W-1:0]  stallCycles;
    logic [TO_W-1:0]   memStallRun;    // consecutive memory-stall cycles, saturating
    logic              memTimeout;

    logic              memStall;
    logic              loadUse;
    logic              flush;
    logic              stallFront;
    logic              stallBack;
    logic              bubbleWb;
    logic [1:0]        sel1Ex;
    logic [1:0]        sel2Ex;
    logic              sel1Id;
    logic              sel2Id;

    function automatic logic isMatch(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] w,
                                     input logic              we);
        return we && (a == w) && !((ZERO_REG_EN != 0) && (a == '0));
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        sel1Ex     = 2'd0;
        sel2Ex     = 2'd0;
        sel1Id     = 1'b0;
        sel2Id     = 1'b0;
        flush      = 1'b0;
        stallFront = 1'b0;
        stallBack  = 1'b0;
        bubbleWb   = 1'b0;

        memStall = hz.MemReq_MEM & ~hz.MemReady_MEM;
        loadUse  = hz.MemRead_EX &
                   (isMatch(hz.Rs_ID, hz.WriteRegAddress_EX, hz.RegWrite_EX) |
                    (hz.UsesRt_ID & isMatch(hz.Rt_ID, hz.WriteRegAddress_EX, hz.RegWrite_EX)));

        if (!Reset) begin
            // A load sitting in MEM has no result yet, so it never wins the
            // MEM bypass; the selection falls through to WB or the latch.
            if (isMatch(hz.Rs_EX, hz.WriteRegAddress_MEM, hz.RegWrite_MEM) && !hz.MemRead_MEM)
                sel1Ex = 2'd1;
            else if (isMatch(hz.Rs_EX, hz.WriteRegAddress_WB, hz.RegWrite_WB))
                sel1Ex = 2'd2;

            if (isMatch(hz.Rt_EX, hz.WriteRegAddress_MEM, hz.RegWrite_MEM) && !hz.MemRead_MEM)
                sel2Ex = 2'd1;
            else if (isMatch(hz.Rt_EX, hz.WriteRegAddress_WB, hz.RegWrite_WB))
                sel2Ex = 2'd2;

            sel1Id = isMatch(hz.Rs_ID, hz.WriteRegAddress_WB, hz.RegWrite_WB);
            sel2Id = isMatch(hz.Rt_ID, hz.WriteRegAddress_WB, hz.RegWrite_WB);

            // Memory freeze outranks bubble insertion; in BUBBLE the pending
            // hazard is already being served, so LoadUse is not consulted.
            flush      = !memStall && ((state == BUBBLE) || loadUse);
            stallBack  = memStall;
            bubbleWb   = memStall;
            stallFront = memStall | flush;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values and the block order does not matter.
        if (Reset) begin
            state       <= RUN;
            remaining   <= 2'd0;
            stallCycles <= '0;
            memStallRun <= '0;
            memTimeout  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!memStall && loadUse && (LOAD_USE_BUBBLES > 1)) begin
                        state     <= BUBBLE;
                        remaining <= BUBBLES_LEFT;
                    end
                end
                BUBBLE: begin
                    if (!memStall) begin
                        remaining <= remaining - 2'd1;
                        if (remaining == 2'd1)
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if ((stallFront || stallBack) && (stallCycles != '1))
                stallCycles <= stallCycles + 1'b1;

            if (memStall) begin
                if (memStallRun != TO_SAT)
                    memStallRun <= memStallRun + 1'b1;
                if (memStallRun == TO_LAST)
                    memTimeout <= 1'b1;
            end else begin
                memStallRun <= '0;
            end
        end
    end

    assign hz.ReadData1Sel_EX = sel1Ex;
    assign hz.ReadData2Sel_EX = sel2Ex;
    assign hz.ReadData1Sel_ID = sel1Id;
    assign hz.ReadData2Sel_ID = sel2Id;
    assign hz.Flush_EX        = flush;
    assign hz.Stall_Front     = stallFront;
    assign hz.Stall_Back      = stallBack;
    assign hz.Bubble_WB       = bubbleWb;
    assign hz.StallCycles     = stallCycles;
    assign hz.MemTimeout      = memTimeout;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_forward_hazard_unit
//   Three instances with different parameter sets share one stimulus stream:
//     inst 0: LOAD_USE_BUBBLES=1, ZERO_REG_EN=1, MEM_TIMEOUT=64
//     inst 1: LOAD_USE_BUBBLES=2, ZERO_REG_EN=0, MEM_TIMEOUT=4
//     inst 2: LOAD_USE_BUBBLES=3, ZERO_REG_EN=1, MEM_TIMEOUT=4
//   StallCycles is narrowed to 6 bits so saturation is reachable.
//   A reference model tracks owed bubbles, stall count and memory-stall run
//   length as plain integers.
// ---------------------------------------------------------------------------
module tb_forward_hazard_unit;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int CW = 6;
    localparam int BUB  [N] = '{1, 2, 3};
    localparam int ZEN  [N] = '{1, 0, 1};
    localparam int TOUT [N] = '{64, 4, 4};

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic [AW-1:0] Rs_ID, Rt_ID, Rs_EX, Rt_EX;
    logic [AW-1:0] WrEX, WrMEM, WrWB;
    logic UsesRt_ID, RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM;
    logic MemReq_MEM, MemReady_MEM, RegWrite_WB;

    logic          oSel1Id [N];
    logic          oSel2Id [N];
    logic [1:0]    oSel1Ex [N];
    logic [1:0]    oSel2Ex [N];
    logic          oStallF [N];
    logic          oStallB [N];
    logic          oFlush  [N];
    logic          oBubWb  [N];
    logic [CW-1:0] oCnt    [N];
    logic          oTo     [N];

    for (genvar g = 0; g < N; g++) begin : gInst
        forward_hazard_unit_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

        assign bus.Rs_ID               = Rs_ID;
        assign bus.Rt_ID               = Rt_ID;
        assign bus.UsesRt_ID           = UsesRt_ID;
        assign bus.Rs_EX               = Rs_EX;
        assign bus.Rt_EX               = Rt_EX;
        assign bus.RegWrite_EX         = RegWrite_EX;
        assign bus.MemRead_EX          = MemRead_EX;
        assign bus.WriteRegAddress_EX  = WrEX;
        assign bus.RegWrite_MEM        = RegWrite_MEM;
        assign bus.MemRead_MEM         = MemRead_MEM;
        assign bus.WriteRegAddress_MEM = WrMEM;
        assign bus.MemReq_MEM          = MemReq_MEM;
        assign bus.MemReady_MEM        = MemReady_MEM;
        assign bus.RegWrite_WB         = RegWrite_WB;
        assign bus.WriteRegAddress_WB  = WrWB;

        forward_hazard_unit #(
            .ADDR_W          (AW),
            .LOAD_USE_BUBBLES(BUB[g]),
            .ZERO_REG_EN     (ZEN[g]),
            .MEM_TIMEOUT     (TOUT[g]),
            .CNT_W           (CW)
        ) dut (
            .Clk  (Clk),
            .Reset(Reset),
            .hz   (bus)
        );

        assign oSel1Id[g] = bus.ReadData1Sel_ID;
        assign oSel2Id[g] = bus.ReadData2Sel_ID;
        assign oSel1Ex[g] = bus.ReadData1Sel_EX;
        assign oSel2Ex[g] = bus.ReadData2Sel_EX;
        assign oStallF[g] = bus.Stall_Front;
        assign oStallB[g] = bus.Stall_Back;
        assign oFlush[g]  = bus.Flush_EX;
        assign oBubWb[g]  = bus.Bubble_WB;
        assign oCnt[g]    = bus.StallCycles;
        assign oTo[g]     = bus.MemTimeout;
    end

    // Reference model state
    int pend     [N];   // bubbles still owed for the hazard being served
    int scnt     [N];
    int consec   [N];
    bit mto      [N];
    int flushCnt [N];

    int checks   = 0;
    int failures = 0;
    bit stallMode;

    task automatic check(input string tag, input int inst,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, exp);
        end
    endtask

    function automatic bit mt(input int a, input int w, input bit we, input int zen);
        return we && (a == w) && !(zen != 0 && a == 0);
    endfunction

    function automatic int exSel(input int a, input int zen);
        if (mt(a, int'(WrMEM), RegWrite_MEM, zen) && !MemRead_MEM) return 1;
        if (mt(a, int'(WrWB), RegWrite_WB, zen)) return 2;
        return 0;
    endfunction

    // One clock cycle: compare every output against the model, then advance
    // the model across the rising edge.
    task automatic step();
        bit ms, lu, fl, sf, sb;
        #1;
        ms = MemReq_MEM && !MemReady_MEM;
        for (int i = 0; i < N; i++) begin
            lu = MemRead_EX && (mt(int'(Rs_ID), int'(WrEX), RegWrite_EX, ZEN[i]) ||
                                (UsesRt_ID && mt(int'(Rt_ID), int'(WrEX), RegWrite_EX, ZEN[i])));
            fl = !Reset && !ms && (pend[i] > 0 || lu);
            sf = !Reset && (ms || fl);
            sb = !Reset && ms;

            check("sel1Ex", i, 32'(oSel1Ex[i]), Reset ? 0 : exSel(int'(Rs_EX), ZEN[i]));
            check("sel2Ex", i, 32'(oSel2Ex[i]), Reset ? 0 : exSel(int'(Rt_EX), ZEN[i]));
            check("sel1Id", i, 32'(oSel1Id[i]), 32'(!Reset && mt(int'(Rs_ID), int'(WrWB), RegWrite_WB, ZEN[i])));
            check("sel2Id", i, 32'(oSel2Id[i]), 32'(!Reset && mt(int'(Rt_ID), int'(WrWB), RegWrite_WB, ZEN[i])));
            check("flush",  i, 32'(oFlush[i]),  32'(fl));
            check("stallF", i, 32'(oStallF[i]), 32'(sf));
            check("stallB", i, 32'(oStallB[i]), 32'(sb));
            check("bubWb",  i, 32'(oBubWb[i]),  32'(sb));
            check("stallCnt", i, 32'(oCnt[i]),  scnt[i]);
            check("memTo",  i, 32'(oTo[i]),     32'(mto[i]));
            if (oFlush[i] === 1'b1) flushCnt[i]++;

            if (Reset) begin
                pend[i] = 0; scnt[i] = 0; consec[i] = 0; mto[i] = 0;
            end else begin
                if (fl) pend[i] = (pend[i] > 0) ? pend[i] - 1 : BUB[i] - 1;
                if ((sf || sb) && scnt[i] < (2 ** CW) - 1) scnt[i]++;
                consec[i] = ms ? consec[i] + 1 : 0;
                if (consec[i] >= TOUT[i]) mto[i] = 1;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle();
        Rs_ID = '0; Rt_ID = '0; UsesRt_ID = 1'b0; Rs_EX = '0; Rt_EX = '0;
        RegWrite_EX = 1'b0; MemRead_EX = 1'b0; WrEX = '0;
        RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; WrMEM = '0;
        MemReq_MEM = 1'b0; MemReady_MEM = 1'b1; RegWrite_WB = 1'b0; WrWB = '0;
    endtask

    task automatic resetPulse();
        Reset = 1'b1;
        idle();
        step();
        Reset = 1'b0;
        for (int i = 0; i < N; i++) flushCnt[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; scnt[i] = 0; consec[i] = 0; mto[i] = 0; flushCnt[i] = 0;
        end
        Reset = 1'b1;
        idle();
        @(negedge Clk);
        step();
        resetPulse();

        // EX forwarding priority: MEM beats WB, then WB alone.
        Rs_EX = 5; RegWrite_MEM = 1'b1; WrMEM = 5; RegWrite_WB = 1'b1; WrWB = 5;
        #1 check("exPrioMem", 0, 32'(oSel1Ex[0]), 1);
        step();
        RegWrite_MEM = 1'b0;
        #1 check("exPrioWb", 0, 32'(oSel1Ex[0]), 2);
        step();

        // Register 0 suppression (inst 0) versus no suppression (inst 1).
        idle();
        RegWrite_MEM = 1'b1; RegWrite_WB = 1'b1;
        #1;
        check("zeroEx",   0, 32'(oSel2Ex[0]), 0);
        check("zeroId",   0, 32'(oSel2Id[0]), 0);
        check("noZeroEx", 1, 32'(oSel2Ex[1]), 1);
        check("noZeroId", 1, 32'(oSel2Id[1]), 1);
        step();

        // Load-use with two bubbles (inst 1).
        resetPulse();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WrEX = 8; Rs_ID = 8; Rs_EX = 3;
        step();
        MemRead_EX = 1'b0; RegWrite_EX = 1'b0; WrEX = 0;
        RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1; WrMEM = 8;
        step();
        RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; WrMEM = 0;
        RegWrite_WB = 1'b1; WrWB = 8; Rs_EX = 8;
        #1;
        check("lu2Flushes",  1, flushCnt[1], 2);
        check("lu2Done",     1, 32'(oFlush[1]), 0);
        check("lu2StallCnt", 1, 32'(oCnt[1]), 2);
        check("lu2Consumer", 1, 32'(oSel1Ex[1]), 2);
        step();

        // Rt-only dependency: ignored unless UsesRt_ID.
        resetPulse();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WrEX = 9; Rt_ID = 9; Rs_ID = 1;
        #1 check("rtUnused", 0, 32'(oFlush[0]), 0);
        step();
        UsesRt_ID = 1'b1;
        #1 check("rtUsed", 0, 32'(oFlush[0]), 1);
        step();
        idle();
        #1 check("rtOneBubble", 0, 32'(oFlush[0]), 0);
        step();

        // Memory wait in the middle of a three-bubble sequence (inst 2).
        resetPulse();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WrEX = 8; Rs_ID = 8;
        step();
        idle();
        MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
        repeat (4) begin
            #1;
            check("waitStallB", 2, 32'(oStallB[2]), 1);
            check("waitBubWb",  2, 32'(oBubWb[2]), 1);
            check("waitNoFlush", 2, 32'(oFlush[2]), 0);
            step();
        end
        MemReq_MEM = 1'b0; MemReady_MEM = 1'b1;
        repeat (3) step();
        #1;
        check("waitFlushes",  2, flushCnt[2], 3);
        check("waitStallCnt", 2, 32'(oCnt[2]), 7);

        // Timeout with MEM_TIMEOUT=4 (inst 1), sticky after ready.
        resetPulse();
        MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
        repeat (3) step();
        #1 check("toBefore", 1, 32'(oTo[1]), 0);
        step();
        #1;
        check("toSet",     1, 32'(oTo[1]), 1);
        check("toDefault", 0, 32'(oTo[0]), 0);
        step();
        MemReady_MEM = 1'b1;
        step();
        #1 check("toSticky", 1, 32'(oTo[1]), 1);

        // Reset in the middle of a bubble sequence (inst 2).
        idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; WrEX = 8; Rs_ID = 8;
        step();
        Rs_EX = 8; RegWrite_MEM = 1'b1; WrMEM = 8; RegWrite_WB = 1'b1; WrWB = 8;
        MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
        Reset = 1'b1;
        #1;
        check("rstFlush",  2, 32'(oFlush[2]), 0);
        check("rstStallF", 2, 32'(oStallF[2]), 0);
        check("rstStallB", 2, 32'(oStallB[2]), 0);
        check("rstSelEx",  2, 32'(oSel1Ex[2]), 0);
        check("rstSelId",  2, 32'(oSel1Id[2]), 0);
        step();
        Reset = 1'b0;
        idle();
        #1;
        check("postRstFlush", 2, 32'(oFlush[2]), 0);
        check("postRstCnt",   2, 32'(oCnt[2]), 0);
        check("postRstTo",    1, 32'(oTo[1]), 0);
        step();

        // StallCycles saturation.
        resetPulse();
        MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
        repeat (70) step();
        #1 check("stallSat", 0, 32'(oCnt[0]), (2 ** CW) - 1);
        idle();
        step();

        // Randomized traffic against the model.
        stallMode = 1'b0;
        repeat (500) begin
            Reset        = ($urandom_range(0, 59) == 0);
            Rs_ID        = AW'($urandom_range(0, 3));
            Rt_ID        = AW'($urandom_range(0, 3));
            Rs_EX        = AW'($urandom_range(0, 3));
            Rt_EX        = AW'($urandom_range(0, 3));
            WrEX         = AW'($urandom_range(0, 3));
            WrMEM        = AW'($urandom_range(0, 3));
            WrWB         = AW'($urandom_range(0, 3));
            UsesRt_ID    = 1'($urandom_range(0, 1));
            RegWrite_EX  = 1'($urandom_range(0, 1));
            MemRead_EX   = 1'($urandom_range(0, 1));
            RegWrite_MEM = 1'($urandom_range(0, 1));
            MemRead_MEM  = 1'($urandom_range(0, 1));
            RegWrite_WB  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) stallMode = !stallMode;
            MemReq_MEM   = stallMode | 1'($urandom_range(0, 1));
            MemReady_MEM = !stallMode;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
